// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM generator with an Avalon-MM slave, a shared prescaler and double-buffered period/duty.
// Define AVALON_PWM_MULTI_IRQ_EN to add CTRL.IRQ_EN and the level-sensitive ins_irq output.
module avalon_pwm_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 16
) (
    input  logic              csi_clk,
    input  logic              csi_reset_n,
    input  logic              avs_chipselect,
    input  logic [3:0]        avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [NUM_CH-1:0] coe_pwm_out
`ifdef AVALON_PWM_MULTI_IRQ_EN
    ,
    output logic              ins_irq
`endif
);

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_PRESCALE = 4'd1;
    localparam logic [3:0] ADDR_PERIOD   = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_DUTY     = 4'd4;

    logic             en;
    logic             pol;
    logic             irq_en;
    logic [PRE_W-1:0] prescale;
    logic [CNT_W-1:0] period_stg;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_stg [NUM_CH];
    logic [CNT_W-1:0] duty_act [NUM_CH];
    logic             pend;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] cnt;

    logic              wr_en;
    logic              rd_en;
    logic [NUM_CH-1:0] duty_wr;
    logic              tick;
    logic              wrap;
    logic [NUM_CH-1:0] raw;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign wr_en = avs_chipselect & avs_write;
    assign rd_en = avs_chipselect & avs_read & ~avs_write;
    assign tick  = en & (pre_cnt == prescale);
    assign wrap  = tick & (cnt >= period_act);
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        duty_wr = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            duty_wr[n] = wr_en && (avs_address == ADDR_DUTY + 4'(n));
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            en         <= 1'b0;
            pol        <= 1'b0;
            prescale   <= '0;
            period_stg <= '1;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_stg[n] <= '0;
            end
        end else begin
            if (wr_en && avs_address == ADDR_CTRL) begin
                en  <= avs_writedata[0];
                pol <= avs_writedata[1];
            end
            if (wr_en && avs_address == ADDR_PRESCALE) begin
                prescale <= avs_writedata[PRE_W-1:0];
            end
            if (wr_en && avs_address == ADDR_PERIOD) begin
                period_stg <= avs_writedata[CNT_W-1:0];
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (duty_wr[n]) begin
                    duty_stg[n] <= avs_writedata[CNT_W-1:0];
                end
            end
        end
    end

`ifdef AVALON_PWM_MULTI_IRQ_EN
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            irq_en  <= 1'b0;
            ins_irq <= 1'b0;
        end else begin
            if (wr_en && avs_address == ADDR_CTRL) begin
                irq_en <= avs_writedata[2];
            end
            ins_irq <= pend & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    // A period-end in the same cycle as a write-1-clear keeps the flag set.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            pend <= 1'b0;
        end else if (wrap) begin
            pend <= 1'b1;
        end else if (wr_en && avs_address == ADDR_STATUS && avs_writedata[0]) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (!en) begin
            pre_cnt <= '0;
            cnt     <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= (cnt >= period_act) ? '0 : cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // While disabled the active copies follow staging so enabling starts with fresh values.
    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            period_act <= '1;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_act[n] <= '0;
            end
        end else if (!en || wrap) begin
            period_act <= period_stg;
            for (int n = 0; n < NUM_CH; n++) begin
                duty_act[n] <= duty_stg[n];
            end
        end
    end

    always_comb begin
        raw = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            raw[n] = en & (cnt < duty_act[n]);
        end
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            coe_pwm_out <= '0;
        end else begin
            coe_pwm_out <= raw ^ {NUM_CH{pol}};
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:     rd_mux = {29'd0, irq_en, pol, en};
            ADDR_PRESCALE: rd_mux = 32'(prescale);
            ADDR_PERIOD:   rd_mux = 32'(period_stg);
            ADDR_STATUS:   rd_mux = {31'd0, pend};
            default: begin
                for (int n = 0; n < NUM_CH; n++) begin
                    if (avs_address == ADDR_DUTY + 4'(n)) begin
                        rd_mux = 32'(duty_stg[n]);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            avs_readdata <= '0;
        end else if (rd_en) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: doc/avalon_pwm_multi.md
Name: avalon_pwm_multi

Overview:
- Parametrised multi-channel PWM generator; Avalon-MM slave on the Nios II system bus.
- Provides a shared programmable prescaler and period counter, with a per-channel duty compare.
- Duty and period writes are double-buffered and take effect only at a period boundary, so outputs never glitch.
- Drives LEDs, motors and similar loads through conduit outputs.

Parameters:
- NUM_CH, 4, number of PWM channels (1..12; limited by the 4-bit address map).
- CNT_W, 16, width of the period counter, PERIOD register and DUTY registers.
- PRE_W, 16, width of the prescaler counter and PRESCALE register.

Ports:
- csi_clk  input  1  system clock; all logic is on its rising edge.
- csi_reset_n  input  1  asynchronous active-low reset.
- avs_chipselect  input  1  slave select.
- avs_address  input  4  word address.
- avs_read  input  1  read strobe.
- avs_readdata  output  32  read data; registered, 1-cycle latency.
- avs_write  input  1  write strobe.
- avs_writedata  input  32  write data.
- coe_pwm_out  output  NUM_CH  PWM outputs; bit n is channel n.

Behaviour:
- Register map (word address):
  - 0 CTRL: bit0 EN, bit1 POL (invert outputs).
  - 1 PRESCALE: tick every PRESCALE+1 clocks.
  - 2 PERIOD: counter runs 0..PERIOD.
  - 3 STATUS: bit0 PEND, sticky period-end flag; write 1 to clear.
  - 4..4+NUM_CH-1: DUTY[n].
  - Unmapped addresses read 0; writes to them are ignored.
  - Unused upper bits of every register read 0.
- Reset values:
  - CTRL=0, PRESCALE=0, PERIOD={CNT_W{1}}.
  - All DUTY staging and active registers = 0; STATUS=0.
  - Counters = 0; avs_readdata=0; coe_pwm_out=0.
- Bus access:
  - Write when chipselect&write; the register updates on the next edge.
  - Read when chipselect&read; avs_readdata is loaded on that edge and valid the following cycle. No wait states.
  - Write and read asserted together: the write is performed and avs_readdata holds its previous value.
  - Reads of PERIOD and DUTY return the staging value, not the active value.
- Prescaler:
  - pre_cnt counts 0..PRESCALE.
  - tick = EN & (pre_cnt==PRESCALE); pre_cnt wraps to 0 on tick.
- Period counter:
  - On tick, cnt wraps to 0 if cnt>=period_act; otherwise cnt increments.
  - Use >=, not ==.
- Period boundary (tick & cnt>=period_act):
  - period_act and every duty_act[n] load from staging.
  - STATUS.PEND sets.
- Set/clear collision: PEND set and write-1-clear in the same cycle leaves PEND=1 (set wins).
- Output generation:
  - raw[n] = EN & (cnt < duty_act[n]); unsigned CNT_W compare.
  - coe_pwm_out[n] is registered as raw[n] ^ POL, giving 1 clock latency from cnt.
  - DUTY=0 gives a constant inactive level.
  - DUTY>PERIOD gives a constant active level.
  - Duty fraction = DUTY/(PERIOD+1).
- EN=0:
  - pre_cnt and cnt are held at 0; no ticks.
  - Active registers track staging every cycle.
  - Outputs sit at the inactive level (POL).
- EN 0->1: the first period starts at cnt=0 with the current staging values.
- PRESCALE written mid-count: takes effect immediately. If pre_cnt>PRESCALE, pre_cnt counts up through the wrap of PRE_W; no special handling.
- Reset asserted mid-operation: all state returns to reset values asynchronously; outputs go to 0 immediately.

Optional Feature:
- Macro: AVALON_PWM_MULTI_IRQ_EN.
- Defined:
  - Adds port ins_irq output 1, placed after coe_pwm_out.
  - Adds CTRL bit2 IRQ_EN (reset 0).
  - ins_irq is registered as STATUS.PEND & IRQ_EN; level-sensitive, deasserted by clearing PEND.
- Undefined:
  - No ins_irq port.
  - CTRL bit2 is not stored and reads 0.
  - PEND remains pollable.

Test Plan:
1. PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=1 -> coe_pwm_out[0] high 3 clocks, low 7 clocks, repeating every 10 clocks; other channels stay 0.
2. DUTY1=0 and DUTY2=10 with PERIOD=9 -> channel 1 constant 0, channel 2 constant 1; no single-cycle glitches across period wraps.
3. Mid-period, write DUTY0=3->7 -> the current period keeps 3 high clocks, the next period has 7; readback of DUTY0 returns 7 immediately.
4. PRESCALE=4, PERIOD=3, DUTY0=2 -> high 10 clocks, low 10 clocks. Write CTRL=3 (POL=1) -> waveform inverted. Write CTRL=2 -> output held at 1.
5. STATUS: PEND sets at the first wrap. A write-1 landing on a wrap cycle leaves PEND=1; a write-1 on a non-wrap cycle gives PEND=0. With IRQ_EN under the macro, ins_irq follows PEND one clock later.
6. Assert csi_reset_n low mid-period -> outputs, readdata and all registers return to reset values asynchronously. After release, PERIOD readback = 0xFFFF (CNT_W=16) and outputs stay 0 until EN is set.
